// File: rtl/beat_pkg.sv
// Shared constants for the buzzer beat timer: beat codes, tempo encodings,
// FSM state encoding and the simulation speed-up divisor.
package beat_pkg;

    // Beat codes: each step halves the note length, starting from a whole note
    localparam logic [3:0] BEAT_WHOLE   = 4'd0;
    localparam logic [3:0] BEAT_HALF    = 4'd1;
    localparam logic [3:0] BEAT_QUARTER = 4'd2;
    localparam logic [3:0] BEAT_8TH     = 4'd3;
    localparam logic [3:0] BEAT_16TH    = 4'd4;
    localparam logic [3:0] BEAT_32ND    = 4'd5;
    localparam logic [3:0] BEAT_64TH    = 4'd6;
    localparam logic [3:0] BEAT_MAX     = BEAT_64TH;

    // Tempo modes
    localparam logic [1:0] TEMPO_X1   = 2'b00;  // nominal
    localparam logic [1:0] TEMPO_X2   = 2'b01;  // twice as long
    localparam logic [1:0] TEMPO_HALF = 2'b10;  // half as long
    localparam logic [1:0] TEMPO_3Q   = 2'b11;  // three quarters as long

    // All durations are divided by this when simulating
    localparam int SIM_DIV = 100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/beat_period_calc.sv
// Combinational beat/tempo/dotted -> note period in clock cycles.
// Arithmetic is done two bits wider than the counter so that x2 and dotted
// scaling cannot wrap; the result saturates to all-ones and never reads 0.
// The whole-note base is assumed to fit in CNT_W bits.
module beat_period_calc
    import beat_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 30,
    parameter int IS_SIM = 0
) (
    input  logic [3:0]       beat,
    input  logic [1:0]       tempo,
    input  logic             dotted,
    output logic [CNT_W-1:0] period,
    output logic             valid
);

    localparam int EXT_W = CNT_W + 2;
    localparam longint unsigned W_FULL = 64'(CLK_HZ) * 64'd2;
    localparam longint unsigned W_BASE = (IS_SIM != 0) ? (W_FULL / 64'(SIM_DIV)) : W_FULL;
    localparam logic [EXT_W-1:0] W_EXT = EXT_W'(W_BASE);

    logic [EXT_W-1:0] p_base;
    logic [EXT_W-1:0] p_tempo;
    logic [EXT_W-1:0] p_dot;

    // Scale the whole note by beat, tempo and dot, then clamp into CNT_W bits
    always_comb begin
        p_base  = W_EXT >> beat;
        p_tempo = p_base;
        case (tempo)
            TEMPO_X2:   p_tempo = p_base << 1;
            TEMPO_HALF: p_tempo = p_base >> 1;
            TEMPO_3Q:   p_tempo = (p_base >> 1) + (p_base >> 2);
            default:    p_tempo = p_base;
        endcase
        p_dot = dotted ? (p_tempo + (p_tempo >> 1)) : p_tempo;

        if (p_dot[EXT_W-1:CNT_W] != 2'b00) begin
            period = '1;
        end else if (p_dot[CNT_W-1:0] == '0) begin
            period = CNT_W'(1);
        end else begin
            period = p_dot[CNT_W-1:0];
        end
        valid = (beat <= BEAT_MAX);
    end

endmodule

// File: rtl/beat_timer.sv
// Note-duration timer for the buzzer music path. Accepts a note on start,
// times its period with pause/abort support and reports busy/done/err.
// Optional articulation gap (gate drops for the last N>>4 cycles) is
// enabled by defining BEAT_TIMER_GAP_EN.
module beat_timer
    import beat_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 30,
    parameter int IS_SIM = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       beat,
    input  logic [1:0]       tempo,
    input  logic             dotted,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             gate,
    output logic             err,
    output logic [CNT_W-1:0] remaining
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] period;
    logic             beat_ok;
    logic             accept;

    beat_period_calc #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W),
        .IS_SIM (IS_SIM)
    ) u_calc (
        .beat   (beat),
        .tempo  (tempo),
        .dotted (dotted),
        .period (period),
        .valid  (beat_ok)
    );

    // A note is taken only from IDLE, which includes the done cycle
    assign accept = (state_q == ST_IDLE) && start && beat_ok;

    // Next-state logic: accept/reject in IDLE, count down with pause/abort in RUN
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    rem_d   = period;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else if (!pause) begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // State, counter and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign err       = err_q;
    assign remaining = rem_q;

`ifdef BEAT_TIMER_GAP_EN
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] gap_d;
    logic [CNT_W-1:0] period_div16;

    assign period_div16 = period >> 4;
    assign gap_d        = (period_div16 == '0) ? CNT_W'(1) : period_div16;

    // Gap length is latched with the note so later input changes cannot move it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else if (accept) begin
            gap_q <= gap_d;
        end
    end

    assign gate = busy && (rem_q > gap_q);
`else
    assign gate = busy;
`endif

endmodule

// File: tb/tb_beat_timer.sv
// Self-checking bench for beat_timer (CLK_HZ=1000, so a whole note is 2000
// cycles). Stimulus pushes expected note outcomes into a queue; a monitor on
// the falling clock edge pops and compares whenever a note ends or err pulses.
module tb_beat_timer;

    localparam int  CNT_W  = 30;
    localparam int  K_DONE = 0;
    localparam int  K_ERR  = 1;
    localparam int  K_NODN = 2;
    localparam longint WHOLE = 2000;

    typedef struct {
        int     kind;
        longint n;
        longint len;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       beat = 4'd0;
    logic [1:0]       tempo = 2'd0;
    logic             dotted = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, gate, err;
    logic [CNT_W-1:0] remaining;

    rec_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    bit     stim_done = 1'b0;

    // monitor state
    bit     prev_busy = 1'b0;
    bit     prev_pause = 1'b0;
    longint rem_exp = 0;
    longint cur_n = 0;
    longint blen = 0;
    int     bad_cycles = 0;
    int     idle_bad = 0;

    beat_timer #(
        .CLK_HZ (1000),
        .CNT_W  (CNT_W),
        .IS_SIM (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .beat      (beat),
        .tempo     (tempo),
        .dotted    (dotted),
        .pause     (pause),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .gate      (gate),
        .err       (err),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // Reference: note length straight from the musical rules
    function automatic longint model_period(input int b, input int t, input bit d);
        longint p;
        p = WHOLE / (longint'(1) << b);
        case (t)
            1: p = p * 2;
            2: p = p / 2;
            3: p = p / 2 + p / 4;
            default: p = p;
        endcase
        if (d) p = p + p / 2;
        if (p > ((longint'(1) << CNT_W) - 1)) p = (longint'(1) << CNT_W) - 1;
        if (p == 0) p = 1;
        return p;
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint expv);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        longint g;
        bit     exp_gate;
        rec_t   r;
        int     act_kind;

        if (!rst_n) begin
            chk(!busy && !done && !gate && !err && remaining == '0, "reset_values",
                {busy, done, gate, err, (remaining != '0)}, 0);
        end

        if (err) begin
            chk(!busy, "err_while_busy", busy, 0);
            chk(exp_q.size() != 0, "err_unexpected", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk(r.kind == K_ERR, "err_kind", K_ERR, r.kind);
                $display("note: err pulse observed");
            end
        end

        if (done) begin
            chk(prev_busy && !busy, "done_position", prev_busy, 1);
        end

        if (prev_busy && !busy) begin
            act_kind = done ? K_DONE : K_NODN;
            chk(exp_q.size() != 0, "end_unexpected", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk(act_kind == r.kind, "end_kind", act_kind, r.kind);
                chk(blen == r.len, "busy_len", blen, r.len);
                chk(bad_cycles == 0, "rem_gate_track", bad_cycles, 0);
                $display("note: N=%0d kind=%0d busy=%0d bad=%0d", r.n, act_kind, blen, bad_cycles);
            end
        end

        if (!prev_busy && busy) begin
            chk(exp_q.size() != 0, "start_unexpected", exp_q.size(), 1);
            cur_n      = (exp_q.size() != 0) ? exp_q[0].n : 0;
            rem_exp    = cur_n;
            blen       = 0;
            bad_cycles = 0;
        end else if (busy && !prev_pause) begin
            rem_exp = rem_exp - 1;
        end

        if (busy) begin
            blen++;
`ifdef BEAT_TIMER_GAP_EN
            g = cur_n >> 4;
            if (g == 0) g = 1;
            exp_gate = (rem_exp > g);
`else
            g = 0;
            exp_gate = 1'b1;
`endif
            if (longint'(remaining) != rem_exp || gate != exp_gate) bad_cycles++;
        end else if (rst_n && (remaining != '0 || gate)) begin
            idle_bad++;
        end

        prev_busy  = busy;
        prev_pause = pause;

        if (stim_done) begin
            chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
            chk(idle_bad == 0, "idle_outputs", idle_bad, 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One note; p_len>0 pauses from busy cycle p_at, ab_at/rst_at>0 abort or
    // reset in that busy cycle, bstart pokes start (random beat) while busy.
    task automatic run_note(input int b, input int t, input bit d, input int p_at,
                            input int p_len, input int ab_at, input int rst_at, input bit bstart);
        rec_t   r;
        longint n, total;
        n = (b <= 6) ? model_period(b, t, d) : 0;
        beat = 4'(b); tempo = 2'(t); dotted = d;
        if (b > 6) begin
            r.kind = K_ERR; r.n = 0; r.len = 0;
            exp_q.push_back(r);
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            step();
            return;
        end
        total  = n + p_len;
        r.n    = n;
        r.kind = (ab_at > 0 || rst_at > 0) ? K_NODN : K_DONE;
        r.len  = (ab_at > 0) ? ab_at : ((rst_at > 0) ? rst_at - 1 : total);
        exp_q.push_back(r);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= total; j++) begin
            pause = (p_len > 0) && (j >= p_at) && (j < p_at + p_len);
            abort = (j == ab_at);
            if (bstart && j < total) begin
                start = ((j % 7) == 3);
                beat  = 4'($urandom_range(0, 15));
                tempo = 2'($urandom_range(0, 3));
            end
            if (j == rst_at) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
                break;
            end
            step();
            if (j == ab_at) break;
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0;
        step();
    endtask

    // k back-to-back notes with start held high throughout
    task automatic run_chain(input int k);
        int   bs[8];
        int   ts[8];
        bit   ds[8];
        rec_t r;
        for (int i = 0; i < k; i++) begin
            bs[i] = $urandom_range(3, 6);
            ts[i] = $urandom_range(0, 3);
            ds[i] = 1'($urandom_range(0, 1));
            r.kind = K_DONE;
            r.n    = model_period(bs[i], ts[i], ds[i]);
            r.len  = r.n;
            exp_q.push_back(r);
        end
        beat = 4'(bs[0]); tempo = 2'(ts[0]); dotted = ds[0];
        start = 1'b1;
        step();
        for (int i = 0; i < k; i++) begin
            repeat (model_period(bs[i], ts[i], ds[i])) step();
            if (i < k - 1) begin
                beat = 4'(bs[i+1]); tempo = 2'(ts[i+1]); dotted = ds[i+1];
            end else begin
                start = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        int b, t, pl, pa, aa;
        bit d;
        longint n;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        run_note(2, 0, 0, 0, 0, 0, 0, 0);    // quarter: 500
        run_note(3, 1, 1, 0, 0, 0, 0, 0);    // 750
        run_note(6, 2, 0, 0, 0, 0, 0, 0);    // 15
        run_note(0, 3, 0, 0, 0, 0, 0, 0);    // 1500
        run_note(9, 0, 0, 0, 0, 0, 0, 0);    // invalid beat
        run_note(2, 0, 0, 0, 0, 0, 0, 1);    // starts while busy ignored
        run_note(4, 0, 0, 30, 40, 0, 0, 0);  // 125 + 40 paused
        run_note(2, 0, 0, 0, 0, 60, 0, 0);   // abort in cycle 60
        run_chain(4);
        run_note(2, 0, 0, 0, 0, 0, 10, 0);   // reset mid-note
        run_note(6, 0, 1, 0, 0, 0, 0, 0);    // short note after reset

        for (int i = 0; i < 14; i++) begin
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(7, 15) : $urandom_range(2, 6);
            t = $urandom_range(0, 3);
            d = 1'($urandom_range(0, 1));
            n = (b <= 6) ? model_period(b, t, d) : 1;
            pl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
            pa = int'($urandom_range(1, 32'(n)));
            aa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32'(n) + 32'(pl))) : 0;
            run_note(b, t, d, pa, pl, aa, 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (3) step();
        stim_done = 1'b1;
    end

    // Hard stop if the run somehow stalls
    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/beat_timer.md
Name: beat_timer

Overview:
- Parametrised note-duration timer for the buzzer music path.
- Converts a beat code (whole to 64th note), a tempo mode and a dotted flag into a cycle count, then times that duration.
- Exposes a start/busy/done handshake to the score sequencer and a gate to the tone generator.
- Successor to the fixed 2-speed beat-count decoder: adds generic clock rate, 4 tempo modes, dotted notes, pause/abort and an optional articulation gap.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- CNT_W, 30, width of the duration counter and of the period value.
- IS_SIM, 0, when 1 all durations are divided by 100 for simulation.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request to time one note; sampled only when busy=0.
- beat  in  4  0=whole (2 s base), 1=half, 2=quarter, 3=8th, 4=16th, 5=32nd, 6=64th, 7..15 invalid.
- tempo  in  2  00 x1, 01 x2 (slow), 10 x1/2 (fast), 11 x3/4.
- dotted  in  1  adds half of the note's own duration.
- pause  in  1  freezes the counter while high.
- abort  in  1  cancels the current note.
- busy  out  1  note being timed.
- done  out  1  one-cycle pulse at normal note completion.
- gate  out  1  tone enable for the tone generator.
- err  out  1  one-cycle pulse when start is accepted with an invalid beat.
- remaining  out  CNT_W  cycles left in the current note.

Behaviour:
- Reset: busy=0, done=0, gate=0, err=0, remaining=0, state IDLE.
- Whole-note base W = 2*CLK_HZ, or 2*CLK_HZ/100 when IS_SIM=1.
- Note period:
  - P0 = W >> beat.
  - Tempo: x2 -> P0<<1; x1/2 -> P0>>1; x3/4 -> (P0>>1)+(P0>>2).
  - Dotted: P = Pt + (Pt>>1).
  - Compute in CNT_W+2 bits, truncating each shift. If the result is >= 2^CNT_W, saturate to 2^CNT_W-1.
  - If the result is 0, force it to 1.
- States: IDLE, RUN.
- IDLE:
  - start=1 with a valid beat: latch period N, remaining<=N, go to RUN.
  - start=1 with an invalid beat: pulse err next cycle, stay IDLE, no done.
- RUN:
  - busy=1 for exactly N unpaused cycles, starting the cycle after start is sampled.
  - remaining decrements by 1 each unpaused cycle.
  - When remaining reaches 0: return to IDLE, busy=0, done=1 for that one cycle.
- Back-to-back notes: start sampled in the done cycle is accepted, giving zero idle cycles between notes.
- start while busy=1 is ignored. Inputs beat/tempo/dotted are sampled only at acceptance.
- pause=1 in RUN: remaining and gate hold their values; busy stays 1. pause in IDLE has no effect.
- abort=1 in RUN: next cycle IDLE, busy=0, gate=0, remaining=0, no done.
- abort has priority over pause. abort together with start in IDLE: start wins.
- gate=busy unless the optional feature is enabled.
- rst_n low mid-note: all outputs return to reset values immediately; no done.

Optional Feature:
- Macro: BEAT_TIMER_GAP_EN.
- Defined: articulation gap. gate=0 during the last G=max(1, N>>4) cycles of the note, i.e. while remaining <= G. busy and done timing are unchanged.
- Not defined: gate=busy; no gap logic is synthesised.

Decomposition:
- Package beat_pkg holds:
  - beat code localparams BEAT_WHOLE..BEAT_64TH and BEAT_MAX=6;
  - tempo encodings TEMPO_X1, TEMPO_X2, TEMPO_HALF, TEMPO_3Q;
  - the state encoding;
  - the SIM_DIV=100 constant.
- Sub-module beat_period_calc: purely combinational beat/tempo/dotted -> saturated period. It is reused by the score preview logic.
- Counter, FSM and gate logic stay in beat_timer.

Test Plan:
- Bench setting for all scenarios: CLK_HZ=1000, IS_SIM=0, so W=2000.
- Quarter note: start with beat=2, tempo=00, dotted=0 -> busy high exactly 500 cycles; done pulses once on cycle 501; remaining counts 500 down to 1.
- Tempo and dotted scaling:
  - beat=3, tempo=01, dotted=1 -> 750 cycles.
  - beat=6, tempo=10 -> 15 cycles (31>>1, truncated).
  - beat=0, tempo=11 -> 1500 cycles.
- Invalid beat and busy start:
  - beat=9 -> err pulse, busy stays 0, no done.
  - start asserted while busy -> ignored, and the period is unchanged.
- Pause and abort:
  - beat=4 (125 cycles) with pause held 40 cycles mid-note -> busy lasts 165 cycles.
  - abort at cycle 60 -> busy=0 next cycle, no done.
- Back-to-back and reset:
  - start held high -> consecutive notes with zero gap, one done per note.
  - rst_n low at cycle 10 -> immediate reset values.
- With BEAT_TIMER_GAP_EN, beat=2 -> gate low for the final 31 of 500 cycles. Without it, gate equals busy.
